// File: rtl/f1_start_lights_fsm.sv
// rtl/f1_start_lights_fsm.sv - start-light sequencer with reaction timing, jump-start and best-time tracking
module f1_start_lights_fsm #(
   parameter int N_LIGHTS = 10,
   parameter int RT_WIDTH = 14
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tick_step,
   input  logic                tick_ms,
   input  logic                trigger,
   input  logic                time_out,
   output logic                en_lfsr,
   output logic                start_delay,
   output logic [N_LIGHTS-1:0] ledr,
   output logic [RT_WIDTH-1:0] rt_ms,
   output logic                rt_valid,
   output logic [RT_WIDTH-1:0] best_ms,
   output logic                jump_start,
   output logic                busy
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_LIGHTING   = 3'd1;
   localparam logic [2:0] S_WAIT_DELAY = 3'd2;
   localparam logic [2:0] S_MEASURE    = 3'd3;
   localparam logic [2:0] S_DONE       = 3'd4;
   localparam logic [2:0] S_FAULT      = 3'd5;

   localparam logic [N_LIGHTS-1:0] LIGHTS_ON  = '1;
   localparam logic [N_LIGHTS-1:0] LIGHTS_OFF = '0;
   localparam logic [RT_WIDTH-1:0] RT_MAX     = '1;
   localparam logic [RT_WIDTH-1:0] RT_ONE     = {{(RT_WIDTH-1){1'b0}}, 1'b1};

   logic [2:0]          state;
   logic [2:0]          state_nx;
   logic [N_LIGHTS-1:0] ledr_nx;
   logic [RT_WIDTH-1:0] ms_cnt;
   logic [RT_WIDTH-1:0] ms_cnt_nx;
   logic [RT_WIDTH-1:0] rt_nx;
   logic [RT_WIDTH-1:0] best_nx;
   logic                start_nx;
   logic                valid_nx;

   // Trigger is checked first in every state so a jump start always beats a tick or time_out.
   always_comb begin
      state_nx  = state;
      ledr_nx   = ledr;
      ms_cnt_nx = ms_cnt;
      rt_nx     = rt_ms;
      best_nx   = best_ms;
      start_nx  = 1'b0;
      valid_nx  = 1'b0;
      case (state)
         S_IDLE: begin
            ledr_nx = LIGHTS_OFF;
            if (trigger) begin
               state_nx = S_LIGHTING;
            end
         end
         S_LIGHTING: begin
            if (trigger) begin
               state_nx = S_FAULT;
               ledr_nx  = LIGHTS_ON;
            end else if (tick_step) begin
               ledr_nx = {ledr[N_LIGHTS-2:0], 1'b1};
               if (&ledr[N_LIGHTS-2:0]) begin
                  state_nx = S_WAIT_DELAY;
                  start_nx = 1'b1;
               end
            end
         end
         S_WAIT_DELAY: begin
            ledr_nx = LIGHTS_ON;
            if (trigger) begin
               state_nx = S_FAULT;
            end else if (time_out) begin
               state_nx  = S_MEASURE;
               ledr_nx   = LIGHTS_OFF;
               ms_cnt_nx = '0;
            end
         end
         S_MEASURE: begin
            ledr_nx = LIGHTS_OFF;
            if (trigger) begin
               // Capture excludes any tick_ms landing in the same cycle as the press.
               state_nx = S_DONE;
               rt_nx    = ms_cnt;
               valid_nx = 1'b1;
               if (ms_cnt < best_ms) begin
                  best_nx = ms_cnt;
               end
            end else if (tick_ms && (ms_cnt != RT_MAX)) begin
               ms_cnt_nx = ms_cnt + RT_ONE;
            end
         end
         S_DONE: begin
            ledr_nx = LIGHTS_OFF;
            if (trigger) begin
               state_nx = S_LIGHTING;
            end
         end
         S_FAULT: begin
            if (trigger) begin
               state_nx = S_LIGHTING;
               ledr_nx  = LIGHTS_OFF;
            end else if (tick_step) begin
               ledr_nx = ~ledr;
            end
         end
         default: begin
            state_nx = S_IDLE;
            ledr_nx  = LIGHTS_OFF;
         end
      endcase
   end

   // Level outputs are decoded from the next state so they line up with ledr and state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         ledr        <= LIGHTS_OFF;
         ms_cnt      <= '0;
         rt_ms       <= '0;
         best_ms     <= RT_MAX;
         rt_valid    <= 1'b0;
         start_delay <= 1'b0;
         en_lfsr     <= 1'b1;
         jump_start  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nx;
         ledr        <= ledr_nx;
         ms_cnt      <= ms_cnt_nx;
         rt_ms       <= rt_nx;
         best_ms     <= best_nx;
         rt_valid    <= valid_nx;
         start_delay <= start_nx;
         en_lfsr     <= !((state_nx == S_WAIT_DELAY) || (state_nx == S_MEASURE));
         jump_start  <= (state_nx == S_FAULT);
         busy        <= (state_nx == S_LIGHTING) || (state_nx == S_WAIT_DELAY) ||
                        (state_nx == S_MEASURE);
      end
   end

endmodule

// File: tb/tb_f1_start_lights_fsm.sv
// tb/tb_f1_start_lights_fsm.sv - vector table, directed rounds and random stimulus against a reference model
module tb_f1_start_lights_fsm;

   localparam int N = 4;
   localparam int BIG = 32'h7fffffff;

   logic clk, rst_n, tick_step, tick_ms, trigger, time_out;
   logic en_lfsr, start_delay, rt_valid, jump_start, busy;
   logic [N-1:0] ledr;
   logic [13:0] rt_ms, best_ms;
   logic s_en_lfsr, s_start_delay, s_rt_valid, s_jump_start, s_busy;
   logic [N-1:0] s_ledr;
   logic [3:0] s_rt_ms, s_best_ms;

   int n_checks = 0;
   int n_fail = 0;

   f1_start_lights_fsm #(.N_LIGHTS(N), .RT_WIDTH(14)) dut (
      .clk(clk), .rst_n(rst_n), .tick_step(tick_step), .tick_ms(tick_ms),
      .trigger(trigger), .time_out(time_out), .en_lfsr(en_lfsr),
      .start_delay(start_delay), .ledr(ledr), .rt_ms(rt_ms), .rt_valid(rt_valid),
      .best_ms(best_ms), .jump_start(jump_start), .busy(busy)
   );

   f1_start_lights_fsm #(.N_LIGHTS(N), .RT_WIDTH(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .tick_step(tick_step), .tick_ms(tick_ms),
      .trigger(trigger), .time_out(time_out), .en_lfsr(s_en_lfsr),
      .start_delay(s_start_delay), .ledr(s_ledr), .rt_ms(s_rt_ms), .rt_valid(s_rt_valid),
      .best_ms(s_best_ms), .jump_start(s_jump_start), .busy(s_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {M_IDLE, M_LIGHT, M_WAIT, M_MEAS, M_DONE, M_FAULT} phase_t;
   phase_t phase;
   int lit, ms, rt, best;
   bit fault_on, start_p, valid_p;

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit trg, input bit stp, input bit tms, input bit tout);
      start_p = 0;
      valid_p = 0;
      if (!r) begin
         phase = M_IDLE; lit = 0; ms = 0; rt = 0; best = BIG; fault_on = 0;
         return;
      end
      case (phase)
         M_IDLE:  if (trg) begin phase = M_LIGHT; lit = 0; end
         M_LIGHT: begin
            if (trg) begin phase = M_FAULT; fault_on = 1; end
            else if (stp) begin
               lit++;
               if (lit == N) begin phase = M_WAIT; start_p = 1; end
            end
         end
         M_WAIT: begin
            if (trg) begin phase = M_FAULT; fault_on = 1; end
            else if (tout) begin phase = M_MEAS; ms = 0; end
         end
         M_MEAS: begin
            if (trg) begin
               rt = ms; valid_p = 1;
               if (ms < best) best = ms;
               phase = M_DONE;
            end else if (tms) ms++;
         end
         M_DONE:  if (trg) begin phase = M_LIGHT; lit = 0; end
         M_FAULT: begin
            if (trg) begin phase = M_LIGHT; lit = 0; end
            else if (stp) fault_on = !fault_on;
         end
         default: phase = M_IDLE;
      endcase
   endtask

   task automatic check_model();
      int e_ledr;
      case (phase)
         M_LIGHT: e_ledr = (1 << lit) - 1;
         M_WAIT:  e_ledr = (1 << N) - 1;
         M_FAULT: e_ledr = fault_on ? (1 << N) - 1 : 0;
         default: e_ledr = 0;
      endcase
      check("m_ledr", 32'(ledr), e_ledr);
      check("m_start_delay", 32'(start_delay), 32'(start_p));
      check("m_en_lfsr", 32'(en_lfsr), 32'(!(phase == M_WAIT || phase == M_MEAS)));
      check("m_busy", 32'(busy), 32'(phase == M_LIGHT || phase == M_WAIT || phase == M_MEAS));
      check("m_jump_start", 32'(jump_start), 32'(phase == M_FAULT));
      check("m_rt_valid", 32'(rt_valid), 32'(valid_p));
      check("m_rt_ms", 32'(rt_ms), sat(rt, 14));
      check("m_best_ms", 32'(best_ms), sat(best, 14));
      check("m_sat_rt_ms", 32'(s_rt_ms), sat(rt, 4));
      check("m_sat_best_ms", 32'(s_best_ms), sat(best, 4));
      check("m_sat_rt_valid", 32'(s_rt_valid), 32'(valid_p));
   endtask

   task automatic cycle(input bit r, input bit trg, input bit stp, input bit tms, input bit tout);
      @(negedge clk);
      rst_n = r; trigger = trg; tick_step = stp; tick_ms = tms; time_out = tout;
      @(posedge clk);
      model_step(r, trg, stp, tms, tout);
      #1;
      check_model();
   endtask

   task automatic ms_ticks(input int n);
      for (int i = 0; i < n; i++) cycle(1, 0, 0, 1, 0);
   endtask

   task automatic light_up();
      for (int i = 0; i < N; i++) cycle(1, 0, 1, 0, 0);
   endtask

   typedef struct {
      bit rst, trg, stp, tms, tout;
      logic [3:0] e_ledr;
      bit e_sd, e_en, e_busy, e_js;
   } vec_t;
   vec_t tv[8];

   initial begin
      rst_n = 1'b0; trigger = 0; tick_step = 0; tick_ms = 0; time_out = 0;
      phase = M_IDLE; lit = 0; ms = 0; rt = 0; best = BIG; fault_on = 0; start_p = 0; valid_p = 0;

      tv[0] = '{0, 0, 0, 0, 0, 4'b0000, 0, 1, 0, 0};
      tv[1] = '{1, 1, 0, 0, 0, 4'b0000, 0, 1, 1, 0};
      tv[2] = '{1, 0, 1, 0, 0, 4'b0001, 0, 1, 1, 0};
      tv[3] = '{1, 0, 1, 0, 0, 4'b0011, 0, 1, 1, 0};
      tv[4] = '{1, 0, 1, 0, 0, 4'b0111, 0, 1, 1, 0};
      tv[5] = '{1, 0, 1, 0, 0, 4'b1111, 1, 0, 1, 0};
      tv[6] = '{1, 0, 0, 0, 0, 4'b1111, 0, 0, 1, 0};
      tv[7] = '{1, 0, 0, 0, 1, 4'b0000, 0, 0, 1, 0};

      for (int i = 0; i < 8; i++) begin
         cycle(tv[i].rst, tv[i].trg, tv[i].stp, tv[i].tms, tv[i].tout);
         check("tv_ledr", 32'(ledr), 32'(tv[i].e_ledr));
         check("tv_start_delay", 32'(start_delay), 32'(tv[i].e_sd));
         check("tv_en_lfsr", 32'(en_lfsr), 32'(tv[i].e_en));
         check("tv_busy", 32'(busy), 32'(tv[i].e_busy));
         check("tv_jump_start", 32'(jump_start), 32'(tv[i].e_js));
      end
      check("reset_best_ms", 32'(best_ms), 32'h3fff);

      ms_ticks(250);
      cycle(1, 1, 0, 0, 0);
      check("r1_rt_ms", 32'(rt_ms), 250);
      check("r1_rt_valid", 32'(rt_valid), 1);
      check("r1_best_ms", 32'(best_ms), 250);
      check("r1_en_lfsr", 32'(en_lfsr), 1);
      check("r1_sat_rt_ms", 32'(s_rt_ms), 15);
      cycle(1, 0, 0, 0, 0);
      check("r1_valid_drop", 32'(rt_valid), 0);

      cycle(1, 1, 0, 0, 0); light_up(); cycle(1, 0, 0, 0, 1);
      ms_ticks(180); cycle(1, 1, 0, 0, 0);
      check("r2_best_ms", 32'(best_ms), 180);
      cycle(1, 1, 0, 0, 0); light_up(); cycle(1, 0, 0, 0, 1);
      ms_ticks(300); cycle(1, 1, 0, 0, 0);
      check("r3_rt_ms", 32'(rt_ms), 300);
      check("r3_best_ms", 32'(best_ms), 180);

      // jump start after two lights
      cycle(1, 1, 0, 0, 0); cycle(1, 0, 1, 0, 0); cycle(1, 0, 1, 0, 0);
      cycle(1, 1, 0, 0, 0);
      check("js_level", 32'(jump_start), 1);
      check("js_ledr", 32'(ledr), 32'hf);
      cycle(1, 0, 1, 0, 0);
      check("js_toggle_off", 32'(ledr), 0);
      cycle(1, 0, 1, 0, 0);
      check("js_toggle_on", 32'(ledr), 32'hf);
      cycle(1, 0, 0, 0, 1);
      check("js_timeout_ignored", 32'(jump_start), 1);
      cycle(1, 1, 0, 0, 0);
      check("js_clear", 32'(jump_start), 0);
      check("js_clear_ledr", 32'(ledr), 0);
      check("js_clear_busy", 32'(busy), 1);

      // saturation in the 4-bit instance, then trigger racing the 6th tick
      light_up(); cycle(1, 0, 0, 0, 1);
      ms_ticks(20); cycle(1, 1, 0, 0, 0);
      check("sat_rt_ms", 32'(s_rt_ms), 15);
      check("sat_wide_rt_ms", 32'(rt_ms), 20);
      cycle(1, 1, 0, 0, 0); light_up(); cycle(1, 0, 0, 0, 1);
      ms_ticks(5); cycle(1, 1, 0, 1, 0);
      check("race_rt_ms", 32'(rt_ms), 5);
      check("race_sat_rt_ms", 32'(s_rt_ms), 5);
      check("race_best_ms", 32'(best_ms), 5);

      // trigger and time_out together
      cycle(1, 1, 0, 0, 0); light_up(); cycle(1, 1, 0, 0, 1);
      check("trg_tout_fault", 32'(jump_start), 1);

      // reset while measuring
      cycle(1, 1, 0, 0, 0); light_up(); cycle(1, 0, 0, 0, 1); ms_ticks(7);
      cycle(0, 0, 0, 0, 0);
      check("rst_best_ms", 32'(best_ms), 32'h3fff);
      check("rst_rt_ms", 32'(rt_ms), 0);
      check("rst_en_lfsr", 32'(en_lfsr), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_ledr", 32'(ledr), 0);

      for (int i = 0; i < 4000; i++) begin
         cycle(($urandom_range(0, 299) != 0),
               ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 1) == 0),
               ($urandom_range(0, 7) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
